// File: rtl/bin2bcd.sv
// Sequential 17-bit binary to 5-digit packed BCD converter (shift-and-add-3).
// One add phase and one shift phase per input bit; fixed 35-cycle latency.
module bin2bcd (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic [16:0] A,
  output logic [19:0] result,
  output logic        done,
  output logic        busy,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [19:0] bcd_r;
  logic [16:0] bin_r;
  logic [4:0]  cnt_r;
  logic        done_r;
  logic        busy_r;
  logic        ovf_r;

  // Add 3 to every BCD digit that is 5 or more, all digits in parallel.
  function automatic logic [19:0] add3_all(input logic [19:0] d);
    logic [19:0] r;
    logic [3:0]  nib;
    r = d;
    for (int i = 0; i < 5; i++) begin
      nib = d[4*i +: 4];
      if (nib >= 4'd5) begin
        r[4*i +: 4] = nib + 4'd3;
      end else begin
        r[4*i +: 4] = nib;
      end
    end
    return r;
  endfunction

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (init) begin
          state_s = ADD;
        end else begin
          state_s = IDLE;
        end
      end
      ADD:   state_s = SHIFT;
      SHIFT: begin
        if (cnt_r == 5'd1) begin
          state_s = DONE;
        end else begin
          state_s = ADD;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and registered handshake outputs, decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= (state_s == DONE);
      busy_r  <= (state_s != IDLE);
    end
  end

  // Datapath: operand capture, digit correction and the combined shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd_r <= 20'd0;
      bin_r <= 17'd0;
      cnt_r <= 5'd0;
      ovf_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (init) begin
            bin_r <= A;
            bcd_r <= 20'd0;
            cnt_r <= 5'd17;
            ovf_r <= (A > 17'd99999);
          end
        end
        ADD: bcd_r <= add3_all(bcd_r);
        SHIFT: begin
          // The bit leaving bcd[19] is dropped, which yields A mod 100000.
          {bcd_r, bin_r} <= {bcd_r[18:0], bin_r, 1'b0};
          cnt_r          <= cnt_r - 5'd1;
        end
        DONE:    ;
        default: ;
      endcase
    end
  end

  assign result = bcd_r;
  assign done   = done_r;
  assign busy   = busy_r;
  assign ovf    = ovf_r;

endmodule

// File: tb/tb_bin2bcd.sv
// Directed bench for bin2bcd: vector table plus hand-written handshake,
// init-while-busy, held-init and mid-conversion reset sequences.
module tb_bin2bcd;

  logic        clk;
  logic        rst;
  logic        init;
  logic [16:0] A;
  logic [19:0] result;
  logic        done;
  logic        busy;
  logic        ovf;

  int total;
  int bad;

  bin2bcd dut (
    .clk    (clk),
    .rst    (rst),
    .init   (init),
    .A      (A),
    .result (result),
    .done   (done),
    .busy   (busy),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] a;
    logic [19:0] exp_res;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Start one conversion and check latency, busy width, result and ovf.
  task automatic run_conv(input logic [16:0] a, input logic [19:0] er, input logic eo);
    int n;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    A    = a;
    init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init     = 1'b0;
    busy_cnt = busy ? 1 : 0;
    seen     = 1'b0;
    n        = 0;
    while (!seen && n < 60) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
    end
    chk($sformatf("latency A=%0d", a), n, 34);
    chk($sformatf("busy_cycles A=%0d", a), busy_cnt, 35);
    chk($sformatf("result A=%0d", a), {12'd0, result}, {12'd0, er});
    chk($sformatf("ovf A=%0d", a), {31'd0, ovf}, {31'd0, eo});
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("done_one_cycle A=%0d", a), {31'd0, done}, 32'd0);
    chk($sformatf("busy_clear A=%0d", a), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n_done;
    int done_at;
    bit any_done;
    logic [19:0] held;

    total = 0;
    bad   = 0;
    vecs[0] = '{17'd0,      20'h00000, 1'b0};
    vecs[1] = '{17'd12345,  20'h12345, 1'b0};
    vecs[2] = '{17'd99999,  20'h99999, 1'b0};
    vecs[3] = '{17'd10009,  20'h10009, 1'b0};
    vecs[4] = '{17'd131071, 20'h31071, 1'b1};
    vecs[5] = '{17'd7,      20'h00007, 1'b0};
    vecs[6] = '{17'd100000, 20'h00000, 1'b1};
    vecs[7] = '{17'd65535,  20'h65535, 1'b0};
    vecs[8] = '{17'd1,      20'h00001, 1'b0};
    vecs[9] = '{17'd90909,  20'h90909, 1'b0};

    // Reset with init high: reset must dominate.
    rst  = 1'b0;
    init = 1'b1;
    A    = 17'd12;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset result", {12'd0, result}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset ovf", {31'd0, ovf}, 32'd0);
    init = 1'b0;
    rst  = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_conv(vecs[i].a, vecs[i].exp_res, vecs[i].exp_ovf);
    end

    // Result and ovf hold with init low.
    run_conv(17'd12345, 20'h12345, 1'b0);
    held     = result;
    any_done = 1'b0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (done) any_done = 1'b1;
    end
    chk("hold result", {12'd0, result}, {12'd0, held});
    chk("hold result value", {12'd0, result}, 32'h12345);
    chk("hold no done", {31'd0, any_done}, 32'd0);

    // init pulses at E5 and E20 while busy are ignored; A changes have no effect.
    @(negedge clk);
    A    = 17'd4095;
    init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_done  = 0;
    done_at = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 5 || n == 20) begin
        init = 1'b1;
        A    = 17'd99999;
      end else begin
        init = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        n_done++;
        done_at = n;
        chk("ignore result", {12'd0, result}, 32'h04095);
      end
    end
    init = 1'b0;
    chk("ignore done count", n_done, 1);
    chk("ignore done edge", done_at, 34);

    // Held init: restart on the first IDLE edge after DONE (E36).
    @(negedge clk);
    A    = 17'd4095;
    init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    done_at = 0;
    for (int n = 1; n <= 36; n++) begin
      if (n == 35) A = 17'd777;
      @(posedge clk);
      @(negedge clk);
      if (done && done_at == 0) begin
        done_at = n;
        chk("held first result", {12'd0, result}, 32'h04095);
      end
      if (n == 35) chk("held idle gap busy", {31'd0, busy}, 32'd0);
      if (n == 36) chk("held restart busy", {31'd0, busy}, 32'd1);
    end
    init = 1'b0;
    chk("held first done edge", done_at, 34);
    done_at = 0;
    for (int n = 1; n <= 60 && done_at == 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) done_at = n;
    end
    chk("held second done edge", done_at, 34);
    chk("held second result", {12'd0, result}, 32'h00777);

    // Asynchronous reset mid-conversion aborts with no done pulse.
    @(negedge clk);
    A    = 17'd54321;
    init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort result", {12'd0, result}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst      = 1'b1;
    any_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done) any_done = 1'b1;
    end
    chk("abort no done", {31'd0, any_done}, 32'd0);
    run_conv(17'd54321, 20'h54321, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
